sap1_controller: RTL and testbench

Controller-sequencer for the SAP-1 datapath. It generates the six-state T-cycle ring and decodes the opcode held in the instruction register into the control word. The control word drives the program counter, MAR, RAM, IR, accumulator, B register, ALU and output register. Every instruction takes exactly six clocks, and HLT freezes the machine until reset.

---
 rtl/sap1_controller.sv | 168 ++++++++++++++++
 tb/tb_sap1_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state T-cycle ring plus HALT, decoding the
// IR opcode nibble into the datapath control word.
module sap1_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic [5:0] t_state,
   output logic       pc_inc,
   output logic       pc_oe,
   output logic       mar_ld,
   output logic       ram_oe,
   output logic       ir_ld,
   output logic       ir_oe,
   output logic       a_ld,
   output logic       a_oe,
   output logic       b_ld,
   output logic       alu_sub,
   output logic       alu_oe,
   output logic       out_ld,
   output logic       halted
);

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_T1   = 3'd0,
      ST_T2   = 3'd1,
      ST_T3   = 3'd2,
      ST_T4   = 3'd3,
      ST_T5   = 3'd4,
      ST_T6   = 3'd5,
      ST_HALT = 3'd6
   } state_t;

   typedef struct packed {
      logic pc_inc;
      logic pc_oe;
      logic mar_ld;
      logic ram_oe;
      logic ir_ld;
      logic ir_oe;
      logic a_ld;
      logic a_oe;
      logic b_ld;
      logic alu_sub;
      logic alu_oe;
      logic out_ld;
   } ctl_t;

   state_t state_q;
   state_t state_d;
   ctl_t   ctl_d;
   ctl_t   ctl_gated;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_T1;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ctl_d   = '0;
      case (state_q)
         ST_T1: begin
            // run is only honoured here; without it the ring idles in T1
            if (run) begin
               ctl_d.pc_oe  = 1'b1;
               ctl_d.mar_ld = 1'b1;
               state_d      = ST_T2;
            end
         end
         ST_T2: begin
            ctl_d.pc_inc = 1'b1;
            state_d      = ST_T3;
         end
         ST_T3: begin
            ctl_d.ram_oe = 1'b1;
            ctl_d.ir_ld  = 1'b1;
            state_d      = ST_T4;
         end
         ST_T4: begin
            state_d = ST_T5;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ctl_d.ir_oe  = 1'b1;
                  ctl_d.mar_ld = 1'b1;
               end
               OP_OUT: begin
                  ctl_d.a_oe   = 1'b1;
                  ctl_d.out_ld = 1'b1;
               end
               OP_HLT: begin
                  state_d = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            state_d = ST_T6;
            case (opcode)
               OP_LDA: begin
                  ctl_d.ram_oe = 1'b1;
                  ctl_d.a_ld   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctl_d.ram_oe = 1'b1;
                  ctl_d.b_ld   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            state_d = ST_T1;
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               ctl_d.alu_oe  = 1'b1;
               ctl_d.a_ld    = 1'b1;
               ctl_d.alu_sub = (opcode == OP_SUB);
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_T1;
         end
      endcase
   end

   // Controls are silenced combinationally while reset is held, not just after an edge
   assign ctl_gated = rst ? ctl_d : '0;

   assign pc_inc  = ctl_gated.pc_inc;
   assign pc_oe   = ctl_gated.pc_oe;
   assign mar_ld  = ctl_gated.mar_ld;
   assign ram_oe  = ctl_gated.ram_oe;
   assign ir_ld   = ctl_gated.ir_ld;
   assign ir_oe   = ctl_gated.ir_oe;
   assign a_ld    = ctl_gated.a_ld;
   assign a_oe    = ctl_gated.a_oe;
   assign b_ld    = ctl_gated.b_ld;
   assign alu_sub = ctl_gated.alu_sub;
   assign alu_oe  = ctl_gated.alu_oe;
   assign out_ld  = ctl_gated.out_ld;

   assign halted  = (state_q == ST_HALT);

   always_comb begin
      t_state = 6'b000000;
      case (state_q)
         ST_T1:   t_state = 6'b000001;
         ST_T2:   t_state = 6'b000010;
         ST_T3:   t_state = 6'b000100;
         ST_T4:   t_state = 6'b001000;
         ST_T5:   t_state = 6'b010000;
         ST_T6:   t_state = 6'b100000;
         default: t_state = 6'b000000;
      endcase
   end

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: stimulus queues hand-written expected
// control words; a negedge monitor pops and compares them.
module tb_sap1_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [3:0] opcode;
   logic [5:0] t_state;
   logic       pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe;
   logic       a_ld, a_oe, b_ld, alu_sub, alu_oe, out_ld, halted;

   sap1_controller dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .t_state(t_state),
      .pc_inc(pc_inc), .pc_oe(pc_oe), .mar_ld(mar_ld), .ram_oe(ram_oe),
      .ir_ld(ir_ld), .ir_oe(ir_oe), .a_ld(a_ld), .a_oe(a_oe), .b_ld(b_ld),
      .alu_sub(alu_sub), .alu_oe(alu_oe), .out_ld(out_ld), .halted(halted)
   );

   always #5 clk = ~clk;

   localparam logic [11:0] PC_INC  = 12'h800;
   localparam logic [11:0] PC_OE   = 12'h400;
   localparam logic [11:0] MAR_LD  = 12'h200;
   localparam logic [11:0] RAM_OE  = 12'h100;
   localparam logic [11:0] IR_LD   = 12'h080;
   localparam logic [11:0] IR_OE   = 12'h040;
   localparam logic [11:0] A_LD    = 12'h020;
   localparam logic [11:0] A_OE    = 12'h010;
   localparam logic [11:0] B_LD    = 12'h008;
   localparam logic [11:0] ALU_SUB = 12'h004;
   localparam logic [11:0] ALU_OE  = 12'h002;
   localparam logic [11:0] OUT_LD  = 12'h001;
   localparam logic [11:0] NONE    = 12'h000;

   typedef struct {
      string       name;
      logic [18:0] exp;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail   = 0;

   wire [11:0] ctl = {pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe,
                      a_ld, a_oe, b_ld, alu_sub, alu_oe, out_ld};
   wire [18:0] obs = {t_state, halted, ctl};

   // t = 1..6 selects a ring state, t = 0 means HALT
   function automatic logic [18:0] w(int t, logic [11:0] c);
      logic [5:0] ts;
      ts = (t == 0) ? 6'b000000 : (6'b000001 << (t - 1));
      return {ts, (t == 0), c};
   endfunction

   task automatic step(string nm, logic r, logic rn, logic [3:0] op,
                       logic [18:0] e, bit rst_mid = 1'b0);
      @(posedge clk);
      #1;
      rst    = r;
      run    = rn;
      opcode = op;
      if (rst_mid) begin
         #1;
         rst = 1'b0;
      end
      sb.push_back('{nm, e});
   endtask

   task automatic instr(string nm, logic [3:0] op, logic run_rest,
                        logic [11:0] e4, logic [11:0] e5, logic [11:0] e6);
      step({nm, " T1"}, 1'b1, 1'b1,     ~op, w(1, PC_OE | MAR_LD));
      step({nm, " T2"}, 1'b1, run_rest, ~op, w(2, PC_INC));
      step({nm, " T3"}, 1'b1, run_rest, ~op, w(3, RAM_OE | IR_LD));
      step({nm, " T4"}, 1'b1, run_rest, op,  w(4, e4));
      step({nm, " T5"}, 1'b1, run_rest, op,  w(5, e5));
      step({nm, " T6"}, 1'b1, run_rest, op,  w(6, e6));
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         n_checks++;
         if (obs !== cur.exp) begin
            n_fail++;
            $display("FAIL %s: got t_state=%b halted=%b ctl=%b, expected t_state=%b halted=%b ctl=%b",
                     cur.name, obs[18:13], obs[12], obs[11:0],
                     cur.exp[18:13], cur.exp[12], cur.exp[11:0]);
         end
      end
   end

   initial begin
      rst    = 1'b0;
      run    = 1'b0;
      opcode = 4'h0;

      step("reset hold", 1'b0, 1'b0, 4'h0, w(1, NONE));
      step("reset hold run=1", 1'b0, 1'b1, 4'h0, w(1, NONE));
      for (int i = 0; i < 3; i++) step("idle run=0", 1'b1, 1'b0, 4'h0, w(1, NONE));

      instr("LDA", 4'h0, 1'b1, IR_OE | MAR_LD, RAM_OE | A_LD, NONE);
      instr("ADD", 4'h1, 1'b1, IR_OE | MAR_LD, RAM_OE | B_LD, ALU_OE | A_LD);
      instr("SUB", 4'h2, 1'b1, IR_OE | MAR_LD, RAM_OE | B_LD, ALU_OE | A_LD | ALU_SUB);
      instr("OUT", 4'hE, 1'b1, A_OE | OUT_LD, NONE, NONE);
      instr("NOP5", 4'h5, 1'b1, NONE, NONE, NONE);
      instr("NOP7 run drop", 4'h7, 1'b0, NONE, NONE, NONE);
      step("idle after run drop", 1'b1, 1'b0, 4'h1, w(1, NONE));
      step("idle after run drop", 1'b1, 1'b0, 4'h2, w(1, NONE));

      step("ADD2 T1", 1'b1, 1'b1, 4'h9, w(1, PC_OE | MAR_LD));
      step("ADD2 T2", 1'b1, 1'b1, 4'h9, w(2, PC_INC));
      step("ADD2 T3", 1'b1, 1'b1, 4'h9, w(3, RAM_OE | IR_LD));
      step("ADD2 T4", 1'b1, 1'b1, 4'h1, w(4, IR_OE | MAR_LD));
      step("ADD2 rst mid-T5", 1'b1, 1'b1, 4'h1, w(1, NONE), 1'b1);
      step("ADD2 rst held", 1'b0, 1'b1, 4'h1, w(1, NONE));
      instr("fresh OUT", 4'hE, 1'b1, A_OE | OUT_LD, NONE, NONE);

      step("HLT T1", 1'b1, 1'b1, 4'h0, w(1, PC_OE | MAR_LD));
      step("HLT T2", 1'b1, 1'b1, 4'h0, w(2, PC_INC));
      step("HLT T3", 1'b1, 1'b1, 4'h0, w(3, RAM_OE | IR_LD));
      step("HLT T4", 1'b1, 1'b1, 4'hF, w(4, NONE));
      for (int i = 0; i < 20; i++)
         step("halted hold", 1'b1, 1'b1, (i % 2 == 0) ? 4'h0 : 4'hF, w(0, NONE));
      step("rst from HALT", 1'b1, 1'b1, 4'h0, w(1, NONE), 1'b1);
      step("rst held", 1'b0, 1'b1, 4'h0, w(1, NONE));
      instr("LDA after HALT", 4'h0, 1'b1, IR_OE | MAR_LD, RAM_OE | A_LD, NONE);
      step("T1 after LDA", 1'b1, 1'b1, 4'h3, w(1, PC_OE | MAR_LD));

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
